// File: rtl/pll_lock_seq_pkg.sv
// Shared types, widths and default timing for the PLL lock sequencer.
package pll_lock_seq_pkg;

    localparam int unsigned P_W = 6;
    localparam int unsigned M_W = 10;
    localparam int unsigned S_W = 3;
    localparam int unsigned STATE_W = 3;

    localparam int unsigned DEF_RST_CYC      = 256;
    localparam int unsigned DEF_LOCK_TIMEOUT = 4096;
    localparam int unsigned DEF_LOCK_FILT    = 4;
    localparam int unsigned DEF_MAX_RETRY    = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_ERROR     = 3'd4
    } state_e;

    typedef struct packed {
        logic [P_W-1:0] p;
        logic [M_W-1:0] m;
        logic [S_W-1:0] s;
    } pms_t;

    // Bits needed to hold values 0..n, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pll_lock_filt.sv
// Two-flop synchronizer for the asynchronous PLL lock, followed by a
// debounce: rise after LOCK_FILT high samples, fall after two low samples.
module pll_lock_filt
    import pll_lock_seq_pkg::*;
#(
    parameter int unsigned LOCK_FILT = DEF_LOCK_FILT
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_lock,
    output logic o_qlock
);

    localparam int unsigned HI_W = cnt_width(LOCK_FILT);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic [HI_W-1:0] hi_cnt_q, hi_cnt_d;
    logic            lo_seen_q, lo_seen_d;
    logic            qlock_q, qlock_d;

    always_comb begin
        sync1_d   = i_lock;
        sync2_d   = sync1_q;
        hi_cnt_d  = hi_cnt_q;
        lo_seen_d = lo_seen_q;
        qlock_d   = qlock_q;
        if (sync2_q) begin
            lo_seen_d = 1'b0;
            if (hi_cnt_q < HI_W'(LOCK_FILT)) begin
                hi_cnt_d = hi_cnt_q + HI_W'(1);
            end
            if (hi_cnt_d == HI_W'(LOCK_FILT)) begin
                qlock_d = 1'b1;
            end
        end else begin
            hi_cnt_d  = '0;
            lo_seen_d = 1'b1;
            if (lo_seen_q) begin
                qlock_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            hi_cnt_q  <= '0;
            lo_seen_q <= 1'b0;
            qlock_q   <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            hi_cnt_q  <= hi_cnt_d;
            lo_seen_q <= lo_seen_d;
            qlock_q   <= qlock_d;
        end
    end

    assign o_qlock = qlock_q;

endmodule

// File: rtl/pll_lock_seq.sv
// PLL bring-up sequencer: reset pulse, lock wait with bounded retries,
// relock on lock loss and PMS reprogramming, all outputs registered.
module pll_lock_seq
    import pll_lock_seq_pkg::*;
#(
    parameter int unsigned RST_CYC      = DEF_RST_CYC,
    parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int unsigned LOCK_FILT    = DEF_LOCK_FILT,
    parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_enable,
    input  logic               i_cfg_update,
    input  logic [P_W-1:0]     i_p,
    input  logic [M_W-1:0]     i_m,
    input  logic [S_W-1:0]     i_s,
    input  logic               i_lock,
    output logic [P_W-1:0]     o_norm_p,
    output logic [M_W-1:0]     o_norm_m,
    output logic [S_W-1:0]     o_norm_s,
    output logic               o_norm_resetb,
    output logic               o_norm_lock_en,
    output logic               o_norm_bypass,
    output logic               o_pll_ready,
    output logic               o_timeout,
    output logic [STATE_W-1:0] o_state
);

    localparam int unsigned CNT_MAX = (RST_CYC > LOCK_TIMEOUT) ? RST_CYC : LOCK_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int unsigned RTY_W   = cnt_width(MAX_RETRY);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    logic qlock;

    pll_lock_filt #(
        .LOCK_FILT (LOCK_FILT)
    ) u_filt (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_lock  (i_lock),
        .o_qlock (qlock)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [RTY_W-1:0] retry_q, retry_d;
    pms_t             pms_q, pms_d;
    logic             resetb_q, resetb_d;
    logic             lock_en_q, lock_en_d;
    logic             bypass_q, bypass_d;
    logic             ready_q, ready_d;
    logic             timeout_q, timeout_d;
    logic             go_reset, load_pms;

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    // Next state: disable wins, then reprogramming, then lock/timeout events.
    always_comb begin
        state_d   = state_q;
        pms_d     = pms_q;
        retry_d   = retry_q;
        timeout_d = timeout_q;
        go_reset  = 1'b0;
        load_pms  = 1'b0;
        if (!i_enable) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    go_reset = 1'b1;
                    load_pms = 1'b1;
                    retry_d  = '0;
                end
                ST_RESET: begin
                    if (i_cfg_update) begin
                        go_reset = 1'b1;
                        load_pms = 1'b1;
                    end else if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (i_cfg_update) begin
                        go_reset = 1'b1;
                        load_pms = 1'b1;
                    end else if (qlock) begin
                        state_d = ST_LOCKED;
                    end else if (cnt_q == TMO_LAST) begin
                        if (retry_q < RTY_W'(MAX_RETRY)) begin
                            go_reset = 1'b1;
                            retry_d  = retry_q + RTY_W'(1);
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end
                end
                ST_LOCKED: begin
                    // A coincident reprogram and lock loss is a single RESET entry.
                    if (i_cfg_update || !qlock) begin
                        go_reset = 1'b1;
                    end
                    if (i_cfg_update) begin
                        load_pms = 1'b1;
                    end
                    if (!qlock) begin
                        retry_d = '0;
                    end
                end
                ST_ERROR: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        if (go_reset) begin
            state_d = ST_RESET;
        end
        if (load_pms) begin
            pms_d = '{p: i_p, m: i_m, s: i_s};
        end
        cnt_d = (go_reset || (state_d != state_q)) ? '0 : cnt_inc;
        if (state_d == ST_IDLE) begin
            timeout_d = 1'b0;
        end else if ((state_d == ST_ERROR) && (state_q != ST_ERROR)) begin
            timeout_d = 1'b1;
        end
        resetb_d  = (state_d == ST_WAIT_LOCK) || (state_d == ST_LOCKED);
        lock_en_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_LOCKED);
        bypass_d  = (state_d != ST_LOCKED);
        ready_d   = (state_d == ST_LOCKED);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            retry_q   <= '0;
            pms_q     <= '0;
            resetb_q  <= 1'b0;
            lock_en_q <= 1'b0;
            bypass_q  <= 1'b1;
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pms_q     <= pms_d;
            resetb_q  <= resetb_d;
            lock_en_q <= lock_en_d;
            bypass_q  <= bypass_d;
            ready_q   <= ready_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_norm_p       = pms_q.p;
    assign o_norm_m       = pms_q.m;
    assign o_norm_s       = pms_q.s;
    assign o_norm_resetb  = resetb_q;
    assign o_norm_lock_en = lock_en_q;
    assign o_norm_bypass  = bypass_q;
    assign o_pll_ready    = ready_q;
    assign o_timeout      = timeout_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Scoreboard bench for pll_lock_seq: stimulus predicts timed output events,
// a negedge monitor matches every observed output change against them.
module tb_pll_lock_seq;
    import pll_lock_seq_pkg::*;

    localparam int unsigned RST_CYC = 8, LOCK_TIMEOUT = 64, LOCK_FILT = 4, MAX_RETRY = 2;

    logic       i_clk = 1'b0, i_rstn = 1'b0, i_enable = 1'b0, i_cfg_update = 1'b0, i_lock = 1'b0;
    logic [5:0] i_p = '0;
    logic [9:0] i_m = '0;
    logic [2:0] i_s = '0;
    logic [5:0] o_norm_p;
    logic [9:0] o_norm_m;
    logic [2:0] o_norm_s;
    logic       o_norm_resetb, o_norm_lock_en, o_norm_bypass, o_pll_ready, o_timeout;
    logic [2:0] o_state;

    pll_lock_seq #(
        .RST_CYC(RST_CYC), .LOCK_TIMEOUT(LOCK_TIMEOUT), .LOCK_FILT(LOCK_FILT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_enable(i_enable), .i_cfg_update(i_cfg_update),
        .i_p(i_p), .i_m(i_m), .i_s(i_s), .i_lock(i_lock),
        .o_norm_p(o_norm_p), .o_norm_m(o_norm_m), .o_norm_s(o_norm_s),
        .o_norm_resetb(o_norm_resetb), .o_norm_lock_en(o_norm_lock_en), .o_norm_bypass(o_norm_bypass),
        .o_pll_ready(o_pll_ready), .o_timeout(o_timeout), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [2:0] st;
        logic [5:0] p;
        logic [9:0] m;
        logic [2:0] s;
        logic       resetb;
        logic       lock_en;
        logic       bypass;
        logic       ready;
        logic       tmo;
    } obs_t;

    typedef struct {
        int unsigned cyc;
        obs_t        o;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          n_chk = 0, n_fail = 0;
    bit          mon_en = 1'b0;
    pms_t        cur_pms = '0;
    obs_t        prev, now_o;
    exp_t        e;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Output levels implied by the sequencer state, straight from the control table.
    function automatic obs_t model_obs(input state_e st, input pms_t pms, input bit tmo);
        obs_t o;
        o.st      = 3'(st);
        o.p       = pms.p;
        o.m       = pms.m;
        o.s       = pms.s;
        o.resetb  = (st == ST_WAIT_LOCK) || (st == ST_LOCKED);
        o.lock_en = (st == ST_WAIT_LOCK) || (st == ST_LOCKED);
        o.bypass  = (st != ST_LOCKED);
        o.ready   = (st == ST_LOCKED);
        o.tmo     = tmo;
        return o;
    endfunction

    function automatic obs_t sample_dut();
        obs_t o;
        o = '{o_state, o_norm_p, o_norm_m, o_norm_s, o_norm_resetb, o_norm_lock_en,
              o_norm_bypass, o_pll_ready, o_timeout};
        return o;
    endfunction

    // Monitor: every change of the output vector must match the next predicted event.
    always @(negedge i_clk) begin
        now_o = sample_dut();
        if (mon_en) begin
            if (now_o != prev) begin
                n_chk++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: cyc=%0d got=%h none expected", cyc, now_o);
                end else begin
                    e = sb_q.pop_front();
                    if (e.cyc != cyc || e.o != now_o) begin
                        n_fail++;
                        $display("FAIL event: got cyc=%0d obs=%h, required cyc=%0d obs=%h",
                                 cyc, now_o, e.cyc, e.o);
                    end
                end
            end
            if (prev.resetb && now_o.resetb) begin
                n_chk++;
                if ({now_o.p, now_o.m, now_o.s} != {prev.p, prev.m, prev.s}) begin
                    n_fail++;
                    $display("FAIL pms_stable: cyc=%0d got=%h/%h/%h required=%h/%h/%h", cyc,
                             now_o.p, now_o.m, now_o.s, prev.p, prev.m, prev.s);
                end
            end
        end
        prev = now_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int unsigned at, input state_e st, input bit tmo);
        exp_t x;
        x.cyc = at;
        x.o   = model_obs(st, cur_pms, tmo);
        sb_q.push_back(x);
    endtask

    task automatic go_to(input int unsigned c);
        while (cyc < c) @(negedge i_clk);
    endtask

    task automatic drain(input int unsigned budget);
        for (int i = 0; i < budget && sb_q.size() > 0; i++) @(negedge i_clk);
        check("events_pending", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic rand_inputs();
        i_p = 6'($urandom);
        i_m = 10'($urandom);
        i_s = 3'($urandom);
    endtask

    task automatic latch_inputs();
        cur_pms.p = i_p;
        cur_pms.m = i_m;
        cur_pms.s = i_s;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(o_state), 0);
        check({tag, "_resetb"}, 32'(o_norm_resetb), 0);
        check({tag, "_lock_en"}, 32'(o_norm_lock_en), 0);
        check({tag, "_bypass"}, 32'(o_norm_bypass), 1);
        check({tag, "_ready"}, 32'(o_pll_ready), 0);
        check({tag, "_timeout"}, 32'(o_timeout), 0);
        check({tag, "_pms"}, 32'({o_norm_p, o_norm_m, o_norm_s}), 0);
    endtask

    // Lock at negedge l: qlock high after edge l+6, FSM may react on edge l+7.
    function automatic int unsigned lock_at(input int unsigned wait_entry, input int unsigned l);
        return (wait_entry + 1 > l + 7) ? wait_entry + 1 : l + 7;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r, c, u, x, d, dl, lk;

        repeat (3) @(negedge i_clk);
        check_reset_vals("por");

        // Enable at reset release, lock appears 10 cycles later.
        @(negedge i_clk);
        i_rstn = 1'b1;
        mon_en = 1'b1;
        r = cyc;
        rand_inputs();
        i_enable = 1'b1;
        latch_inputs();
        push(r + 1, ST_RESET, 0);
        push(r + 1 + RST_CYC, ST_WAIT_LOCK, 0);
        go_to(r + 10);
        i_lock = 1'b1;
        push(lock_at(r + 1 + RST_CYC, cyc), ST_LOCKED, 0);
        drain(40);

        // One-cycle glitch on lock while locked: nothing may happen.
        c = cyc;
        i_lock = 1'b0;
        @(negedge i_clk);
        i_lock = 1'b1;
        go_to(c + 20);
        check("glitch_ready", 32'(o_pll_ready), 1);

        // Three-cycle drop, then a random-length drop: relock through RESET.
        for (int k = 0; k < 2; k++) begin
            d = (k == 0) ? 3 : $urandom_range(2, 9);
            c = cyc;
            i_lock = 1'b0;
            push(c + 5, ST_RESET, 0);
            push(c + 5 + RST_CYC, ST_WAIT_LOCK, 0);
            push(lock_at(c + 5 + RST_CYC, c + d), ST_LOCKED, 0);
            go_to(c + d);
            i_lock = 1'b1;
            drain(60);
        end

        // Reprogram M=0x0C8 while locked, then again mid-RESET to restart it.
        u = cyc;
        rand_inputs();
        i_m = 10'h0C8;
        i_cfg_update = 1'b1;
        latch_inputs();
        push(u + 1, ST_RESET, 0);
        go_to(u + 1);
        i_cfg_update = 1'b0;
        check("cfg_m", 32'(o_norm_m), 32'h0C8);
        check("cfg_resetb", 32'(o_norm_resetb), 0);
        rand_inputs();
        go_to(u + 4);
        rand_inputs();
        i_m = 10'h137;
        i_cfg_update = 1'b1;
        latch_inputs();
        push(u + 5, ST_RESET, 0);
        push(u + 5 + RST_CYC, ST_WAIT_LOCK, 0);
        push(u + 6 + RST_CYC, ST_LOCKED, 0);
        @(negedge i_clk);
        i_cfg_update = 1'b0;
        rand_inputs();
        drain(40);

        // Disable and reprogram together: IDLE wins, PMS untouched; cfg in IDLE ignored.
        x = cyc;
        i_enable = 1'b0;
        i_cfg_update = 1'b1;
        rand_inputs();
        push(x + 1, ST_IDLE, 0);
        @(negedge i_clk);
        i_cfg_update = 1'b0;
        repeat (3) @(negedge i_clk);
        i_cfg_update = 1'b1;
        rand_inputs();
        @(negedge i_clk);
        i_cfg_update = 1'b0;
        drain(10);
        check("idle_pms_m", 32'(o_norm_m), 32'(cur_pms.m));
        check("idle_state", 32'(o_state), 0);

        // Lock never comes: retries exhaust into ERROR with a sticky timeout.
        i_lock = 1'b0;
        repeat (6) @(negedge i_clk);
        x = cyc;
        rand_inputs();
        i_enable = 1'b1;
        latch_inputs();
        for (int k = 0; k <= int'(MAX_RETRY); k++) begin
            push(x + 1 + k * (RST_CYC + LOCK_TIMEOUT), ST_RESET, 0);
            push(x + 1 + RST_CYC + k * (RST_CYC + LOCK_TIMEOUT), ST_WAIT_LOCK, 0);
        end
        push(x + 1 + (MAX_RETRY + 1) * (RST_CYC + LOCK_TIMEOUT), ST_ERROR, 1);
        @(negedge i_clk);
        rand_inputs();
        drain(300);
        check("err_state", 32'(o_state), 4);
        check("err_timeout", 32'(o_timeout), 1);
        i_cfg_update = 1'b1;
        rand_inputs();
        @(negedge i_clk);
        i_cfg_update = 1'b0;
        repeat (3) @(negedge i_clk);
        x = cyc;
        i_enable = 1'b0;
        push(x + 1, ST_IDLE, 0);
        drain(10);
        check("err_clr_state", 32'(o_state), 0);
        check("err_clr_timeout", 32'(o_timeout), 0);

        // Random lock arrival relative to the reset pulse.
        for (int k = 0; k < 4; k++) begin
            i_lock = 1'b0;
            repeat (6) @(negedge i_clk);
            x = cyc;
            rand_inputs();
            i_enable = 1'b1;
            latch_inputs();
            push(x + 1, ST_RESET, 0);
            push(x + 1 + RST_CYC, ST_WAIT_LOCK, 0);
            dl = $urandom_range(0, 40);
            go_to(x + dl);
            lk = lock_at(x + 1 + RST_CYC, cyc);
            i_lock = 1'b1;
            push(lk, ST_LOCKED, 0);
            go_to(lk + 5);
            push(cyc + 1, ST_IDLE, 0);
            i_enable = 1'b0;
            drain(80);
        end

        // Asynchronous reset in WAIT_LOCK takes effect without a clock edge.
        i_lock = 1'b0;
        repeat (6) @(negedge i_clk);
        x = cyc;
        rand_inputs();
        i_enable = 1'b1;
        latch_inputs();
        push(x + 1, ST_RESET, 0);
        push(x + 1 + RST_CYC, ST_WAIT_LOCK, 0);
        drain(20);
        go_to(x + RST_CYC + 4);
        check("pre_rst_resetb", 32'(o_norm_resetb), 1);
        mon_en = 1'b0;
        #2;
        i_rstn = 1'b0;
        #1;
        check_reset_vals("async");
        i_enable = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rstn = 1'b1;
        repeat (2) @(negedge i_clk);
        check_reset_vals("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_seq.md
PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

Interface
REQ-001 SHALL provide parameter RST_CYC, default 256: number of cycles o_norm_resetb is held low per PLL reset.
REQ-002 SHALL provide parameter LOCK_TIMEOUT, default 4096: maximum number of cycles spent in WAIT_LOCK per attempt.
REQ-003 SHALL provide parameter LOCK_FILT, default 4: number of consecutive synchronized lock-high cycles that qualify lock.
REQ-004 SHALL provide parameter MAX_RETRY, default 3: number of timeout retries allowed before ERROR.
REQ-005 SHALL have port i_clk, input, 1 bit: single clock (PLL reference fin); one clock, all logic on its rising edge.
REQ-006 SHALL have port i_rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port i_enable, input, 1 bit: level-sensitive PLL run request.
REQ-008 SHALL have port i_cfg_update, input, 1 bit: single-cycle pulse requesting a new PMS value.
REQ-009 SHALL have ports i_p, i_m, i_s, inputs, 6/10/3 bits: requested P, M and S divider values.
REQ-010 SHALL have port i_lock, input, 1 bit: PLL lock indicator, asynchronous to i_clk.
REQ-011 SHALL have ports o_norm_p, o_norm_m, o_norm_s, outputs, 6/10/3 bits: registered PMS values driven to the PLL test mux normal inputs.
REQ-012 SHALL have ports o_norm_resetb, o_norm_lock_en, o_norm_bypass, outputs, 1 bit each: PLL control.
REQ-013 SHALL have port o_pll_ready, output, 1 bit: PLL locked and output usable.
REQ-014 SHALL have port o_timeout, output, 1 bit: sticky flag indicating retries were exhausted.
REQ-015 SHALL have port o_state, output, 3 bits: current FSM state encoding.

Function
REQ-016 SHALL synchronize i_lock through 2 flops, then debounce it; qlock rises after LOCK_FILT consecutive high samples and falls after 2 consecutive low samples.
REQ-017 SHALL implement states IDLE=0, RESET=1, WAIT_LOCK=2, LOCKED=3, ERROR=4.
REQ-018 SHALL transition IDLE->RESET when i_enable=1, latching i_p/i_m/i_s into o_norm_p/m/s and clearing the retry count.
REQ-019 SHALL hold o_norm_resetb=0 in RESET for exactly RST_CYC cycles, then transition to WAIT_LOCK.
REQ-020 SHALL drive o_norm_resetb=1 and o_norm_lock_en=1 in WAIT_LOCK, and transition to LOCKED when qlock=1.
REQ-021 SHALL, when a WAIT_LOCK attempt reaches LOCK_TIMEOUT cycles, go to RESET and increment the retry count if retry<MAX_RETRY; otherwise it SHALL go to ERROR and set o_timeout.
REQ-022 SHALL assert o_pll_ready=1 and o_norm_bypass=0 only in LOCKED; both SHALL be registered and follow the state with 0 cycles of additional delay.
REQ-023 SHALL, in LOCKED, go to RESET on a qlock fall (relock); the retry count SHALL be cleared on that transition.
REQ-024 SHALL, on i_cfg_update in RESET, WAIT_LOCK or LOCKED, latch the new PMS value and restart RESET with its counter reloaded; i_cfg_update in IDLE or ERROR SHALL be ignored.
REQ-025 SHALL, on i_enable=0, go to IDLE from any state next cycle; this SHALL take priority over i_cfg_update, lock events and timeout.
REQ-026 SHALL treat a simultaneous i_cfg_update and qlock fall as one RESET entry.
REQ-027 SHALL change o_norm_p/m/s only on the cycle entering RESET, so PMS never changes while o_norm_resetb=1.
REQ-028 SHALL hold ERROR until i_enable=0; o_timeout SHALL clear on the ERROR->IDLE transition.
REQ-029 SHALL, in IDLE and ERROR, drive o_norm_resetb=0, o_norm_lock_en=0 and o_norm_bypass=1.
REQ-030 SHALL size counters as clog2(max(RST_CYC, LOCK_TIMEOUT))+1 bits, saturating with no wrap.

Reset
REQ-031 SHALL, while i_rstn=0, immediately set state=IDLE, o_norm_resetb=0, o_norm_lock_en=0, o_norm_bypass=1, o_pll_ready=0, o_timeout=0, o_norm_p/m/s=0, all counters=0 and all sync flops=0.
REQ-032 SHALL deassert reset to the FSM normally; the block relies on an external reset synchronizer; an asynchronous reset asserted mid-sequence SHALL abort it with no glitch on o_norm_resetb high.

Structure
REQ-033 SHALL place the state enum, the PMS widths (6/10/3) and the default parameter values in package pll_lock_seq_pkg.
REQ-034 SHALL implement the synchronizer plus debounce filter as sub-module pll_lock_filt, with inputs i_clk/i_rstn/i_lock and output o_qlock.

Verification (RST_CYC=8, LOCK_TIMEOUT=64, LOCK_FILT=4, MAX_RETRY=2)
REQ-035 SHALL check: enable with i_lock high 10 cycles after reset release -> o_norm_resetb low exactly 8 cycles, and o_pll_ready rises 2+4 cycles after lock seen high.
REQ-036 SHALL check: i_lock stuck 0 -> three 64-cycle WAIT_LOCK attempts, then o_state=4 and o_timeout=1; dropping i_enable clears both.
REQ-037 SHALL check: i_lock drops 3 cycles while LOCKED -> o_pll_ready falls and a RESET of 8 cycles follows; a 1-cycle drop SHALL cause no action.
REQ-038 SHALL check: i_cfg_update with M=0x0C8 in LOCKED -> o_norm_m=0x0C8 on the same edge o_norm_resetb goes low, with the PMS outputs stable while resetb is high.
REQ-039 SHALL check: i_enable=0 and i_cfg_update in the same cycle -> IDLE and PMS unchanged.
REQ-040 SHALL check: i_rstn asserted in WAIT_LOCK -> all outputs take their reset values asynchronously.
